mem_array: RTL and testbench

MEM_ARRAY -- requirements
Module: mem_array

---
 rtl/mem_array.sv | 173 +++++++++++++++++
 tb/tb_mem_array.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_array.sv
// Two-port round-robin front end onto one byte-writable block RAM, one access per cycle.
// Define MEM_OUTREG_EN to add an output register stage (completion latency 2 instead of 1).
module mem_array #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [WORD_W/8-1:0]   a_be,
  input  logic [WORD_W-1:0]     a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [WORD_W-1:0]     a_rdata,
  output logic                  a_err,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [WORD_W/8-1:0]   b_be,
  input  logic [WORD_W-1:0]     b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [WORD_W-1:0]     b_rdata,
  output logic                  b_err
);
  localparam int NB    = WORD_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NB - 1);
  localparam logic [ADDR_W-1:0] DEPTH_W    = ADDR_W'(DEPTH);

  // 0 = port a, 1 = port b
  logic last_gnt_reg;

  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [NB-1:0]     sel_be;
  logic [WORD_W-1:0] sel_wdata;
  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  ram_idx;
  logic              accept;
  logic              bad_addr;
  logic              wr_en;
  logic              rd_en;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] ram_q_reg;

  logic              s1_valid_reg;
  logic              s1_port_reg;
  logic              s1_err_reg;
  logic              s1_rd_reg;
  logic [WORD_W-1:0] s1_data;

  logic              out_valid;
  logic              out_port;
  logic              out_err;
  logic [WORD_W-1:0] out_data;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (a_req && (!b_req || last_gnt_reg))
        a_gnt = 1'b1;
      else if (b_req)
        b_gnt = 1'b1;
    end
  end

  assign accept    = a_gnt | b_gnt;
  assign sel_port  = b_gnt;
  assign sel_we    = sel_port ? b_we    : a_we;
  assign sel_addr  = sel_port ? b_addr  : a_addr;
  assign sel_be    = sel_port ? b_be    : a_be;
  assign sel_wdata = sel_port ? b_wdata : a_wdata;

  assign word_idx  = sel_addr >> OFF_W;
  assign ram_idx   = word_idx[IDX_W-1:0];
  assign bad_addr  = ((sel_addr & ALIGN_MASK) != '0) || (word_idx >= DEPTH_W);
  assign wr_en     = accept && sel_we && !bad_addr;
  assign rd_en     = accept && !sel_we && !bad_addr;

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_gnt_reg <= 1'b1;
    else if (accept)
      last_gnt_reg <= sel_port;
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (sel_be[i])
          mem[ram_idx][i*8 +: 8] <= sel_wdata[i*8 +: 8];
      end
    end
    if (rd_en)
      ram_q_reg <= mem[ram_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_port_reg  <= 1'b0;
      s1_err_reg   <= 1'b0;
      s1_rd_reg    <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      s1_port_reg  <= sel_port;
      s1_err_reg   <= accept && bad_addr;
      s1_rd_reg    <= rd_en;
    end
  end

  // Writes and errors complete with zero data.
  assign s1_data = s1_rd_reg ? ram_q_reg : '0;

`ifdef MEM_OUTREG_EN
  logic              s2_valid_reg;
  logic              s2_port_reg;
  logic              s2_err_reg;
  logic [WORD_W-1:0] s2_data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_port_reg  <= 1'b0;
      s2_err_reg   <= 1'b0;
      s2_data_reg  <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_port_reg  <= s1_port_reg;
      s2_err_reg   <= s1_err_reg;
      s2_data_reg  <= s1_data;
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_port  = s2_port_reg;
  assign out_err   = s2_err_reg;
  assign out_data  = s2_data_reg;
`else
  assign out_valid = s1_valid_reg;
  assign out_port  = s1_port_reg;
  assign out_err   = s1_err_reg;
  assign out_data  = s1_data;
`endif

  // Gating with rst_n hides an in-flight completion as soon as reset is asserted.
  logic [1:0]        rvalid_vec;
  logic [1:0]        err_vec;
  logic [WORD_W-1:0] rdata_vec [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_port_out
    assign rvalid_vec[gi] = rst_n && out_valid && (out_port == 1'(gi));
    assign err_vec[gi]    = rvalid_vec[gi] && out_err;
    assign rdata_vec[gi]  = rvalid_vec[gi] ? out_data : '0;
  end

  assign a_rvalid = rvalid_vec[0];
  assign a_err    = err_vec[0];
  assign a_rdata  = rdata_vec[0];
  assign b_rvalid = rvalid_vec[1];
  assign b_err    = err_vec[1];
  assign b_rdata  = rdata_vec[1];

endmodule

// File: tb/tb_mem_array.sv
// Directed self-checking bench for mem_array; follows MEM_OUTREG_EN for the expected latency.
module tb_mem_array;
`ifdef MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 4096;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_we, a_gnt, a_rvalid, a_err;
  logic [18:0] a_addr;
  logic [3:0]  a_be;
  logic [31:0] a_wdata, a_rdata;
  logic        b_req, b_we, b_gnt, b_rvalid, b_err;
  logic [18:0] b_addr;
  logic [3:0]  b_be;
  logic [31:0] b_wdata, b_rdata;

  int tests_run;
  int tests_failed;

  typedef struct {
    bit          port;
    bit          we;
    logic [18:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } txn_t;

  txn_t q[$];

  mem_array dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_be = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_be = '0; b_wdata = '0;
  endtask

  task automatic drive(input txn_t t);
    if (t.port) begin
      b_req = 1'b1; b_we = t.we; b_addr = t.addr; b_be = t.be; b_wdata = t.wdata;
    end else begin
      a_req = 1'b1; a_we = t.we; a_addr = t.addr; a_be = t.be; a_wdata = t.wdata;
    end
  endtask

  task automatic add(input bit port, input bit we, input logic [18:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input logic [31:0] rdata, input bit err);
    txn_t t;
    t.port = port; t.we = we; t.addr = addr; t.be = be;
    t.wdata = wdata; t.rdata = rdata; t.err = err;
    q.push_back(t);
  endtask

  // Issues queued transactions one per cycle; completion j is expected LAT edges after its accept.
  task automatic run_seq(input string name);
    int   n;
    int   j;
    txn_t t;
    n = q.size();
    for (int i = 0; i < n + LAT - 1; i++) begin
      idle();
      if (i < n) begin
        drive(q[i]);
        #1;
        check($sformatf("%s.gnt%0d", name, i), q[i].port ? b_gnt : a_gnt, 1);
      end
      @(posedge clk); #1;
      j = i - (LAT - 1);
      if (j >= 0) begin
        t = q[j];
        check($sformatf("%s.rvalid%0d", name, j), t.port ? b_rvalid : a_rvalid, 1);
        check($sformatf("%s.other_rvalid%0d", name, j), t.port ? a_rvalid : b_rvalid, 0);
        check($sformatf("%s.rdata%0d", name, j), t.port ? b_rdata : a_rdata, t.rdata);
        check($sformatf("%s.err%0d", name, j), t.port ? b_err : a_err, 32'(t.err));
        $display("[TB] %s #%0d port %s %s addr %h be %b wdata %h -> rdata %h err %0d",
                 name, j, t.port ? "b" : "a", t.we ? "W" : "R", t.addr, t.be, t.wdata,
                 t.port ? b_rdata : a_rdata, t.port ? b_err : a_err);
      end
    end
    idle();
    @(posedge clk); #1;
    check($sformatf("%s.idle_rvalid", name), {a_rvalid, b_rvalid}, 0);
    check($sformatf("%s.idle_rdata", name), a_rdata | b_rdata, 0);
    q.delete();
  endtask

  initial begin
    int j;
    tests_run = 0;
    tests_failed = 0;

    // Reset with both ports requesting writes: nothing may be granted or completed.
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 19'h10; a_be = 4'hF; a_wdata = 32'hBAD0BAD0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 19'h14; b_be = 4'hF; b_wdata = 32'hBAD1BAD1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.a_gnt", a_gnt, 0);
    check("reset.b_gnt", b_gnt, 0);
    check("reset.rvalid", {a_rvalid, b_rvalid}, 0);
    check("reset.a_rdata", a_rdata, 0);
    check("reset.b_rdata", b_rdata, 0);
    check("reset.err", {a_err, b_err}, 0);
    $display("[TB] reset: gnt %b%b rvalid %b%b", a_gnt, b_gnt, a_rvalid, b_rvalid);
    idle();
    rst_n = 1'b1;

    // Both ports read every cycle for 4 accepts: a,b,a,b.
    a_req = 1'b1; a_we = 1'b0; a_addr = 19'h0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 19'h4;
    for (int i = 0; i < 4 + LAT - 1; i++) begin
      if (i < 4) begin
        #1;
        check($sformatf("rr.a_gnt%0d", i), a_gnt, 32'(i % 2 == 0));
        check($sformatf("rr.b_gnt%0d", i), b_gnt, 32'(i % 2 == 1));
      end
      @(posedge clk); #1;
      if (i == 3) idle();
      j = i - (LAT - 1);
      if (j >= 0) begin
        check($sformatf("rr.a_rvalid%0d", j), a_rvalid, 32'(j % 2 == 0));
        check($sformatf("rr.b_rvalid%0d", j), b_rvalid, 32'(j % 2 == 1));
        $display("[TB] rr #%0d rvalid a=%0d b=%0d", j, a_rvalid, b_rvalid);
      end
    end
    idle();
    @(posedge clk); #1;

    // Full write then read-after-write on the next cycle.
    add(0, 1, 19'h10, 4'hF, 32'hDEADBEEF, 32'h0, 0);
    add(0, 0, 19'h10, 4'h0, 32'h0, 32'hDEADBEEF, 0);
    run_seq("wr_rd");

    // Partial byte-enable write merged over the previous word.
    add(1, 1, 19'h10, 4'b0101, 32'h11223344, 32'h0, 0);
    add(0, 0, 19'h10, 4'h0, 32'h0, 32'hDE22BE44, 0);
    run_seq("byte_en");

    // Errors: misaligned read, out-of-range write that would alias word 0 if truncated.
    add(0, 1, 19'h0, 4'hF, 32'h01020304, 32'h0, 0);
    add(0, 0, 19'h12, 4'h0, 32'h0, 32'h0, 1);
    add(1, 1, 19'(DEPTH * 4), 4'hF, 32'hFFFFFFFF, 32'h0, 1);
    add(0, 0, 19'h10, 4'h0, 32'h0, 32'hDE22BE44, 0);
    add(1, 0, 19'h0, 4'h0, 32'h0, 32'h01020304, 0);
    run_seq("errors");

    // be=0 write completes normally and changes nothing; last word is addressable.
    add(1, 1, 19'h10, 4'h0, 32'h55555555, 32'h0, 0);
    add(0, 0, 19'h10, 4'h0, 32'h0, 32'hDE22BE44, 0);
    add(0, 1, 19'((DEPTH - 1) * 4), 4'hF, 32'hA5A5A5A5, 32'h0, 0);
    add(1, 0, 19'((DEPTH - 1) * 4), 4'h0, 32'h0, 32'hA5A5A5A5, 0);
    run_seq("bounds");

    // Back-to-back reads of consecutive words.
    add(1, 1, 19'h4, 4'hF, 32'h44444444, 32'h0, 0);
    add(0, 1, 19'h8, 4'hF, 32'h88888888, 32'h0, 0);
    add(0, 0, 19'h0, 4'h0, 32'h0, 32'h01020304, 0);
    add(0, 0, 19'h4, 4'h0, 32'h0, 32'h44444444, 0);
    add(0, 0, 19'h8, 4'h0, 32'h0, 32'h88888888, 0);
    run_seq("stream");

    // Reset right after an accepted read swallows its completion.
    idle();
    a_req = 1'b1; a_addr = 19'h10;
    #1;
    check("rst_mid.gnt", a_gnt, 1);
    @(posedge clk); #1;
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_mid.rvalid", {a_rvalid, b_rvalid}, 0);
    check("rst_mid.rdata", a_rdata, 0);
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_mid.hold_rvalid", {a_rvalid, b_rvalid}, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_mid.after_rvalid", {a_rvalid, b_rvalid}, 0);
    end
    $display("[TB] rst_mid: in-flight read discarded");

    // Last grant before reset was a; reset must hand the first contended cycle back to a.
    a_req = 1'b1; a_addr = 19'h10;
    b_req = 1'b1; b_addr = 19'h10;
    #1;
    check("rst_rr.a_gnt", a_gnt, 1);
    check("rst_rr.b_gnt", b_gnt, 0);
    idle();
    #1;

    add(1, 0, 19'h10, 4'h0, 32'h0, 32'hDE22BE44, 0);
    run_seq("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
